noc_switch_rr: RTL and testbench
================================

Name: noc_switch_rr

Overview:
Parametrised NoC router crossbar and the successor to the fixed 5-port, 8-bit switch. It moves one flit per output per cycle from any input to any output. Each output has its own round-robin arbiter, which replaces fixed priority. Optional wormhole lock mode keeps an output owned by one input for the length of a packet. Outputs are registered, and backpressure comes from per-output full flags driven by the downstream FIFOs.

Parameters:
NUM_PORTS, 5, number of ports; index 0=L, 1=N, 2=E, 3=S, 4=W.
DATA_W, 8, flit width in bits.
REQ_W, 3, width of each request field; must satisfy 2^REQ_W > NUM_PORTS.
LOCK_MODE, 0, 0 = arbitrate every cycle; 1 = the winner keeps the output until it stops requesting it.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
in_data  input  NUM_PORTS*DATA_W  input flits; slice i = input i.
request  input  NUM_PORTS*REQ_W  slice i = destination output of input i; a value >= NUM_PORTS means idle (all-ones is the idle convention).
full  input  NUM_PORTS  full[o]=1: output o's downstream cannot accept a flit this cycle.
grant  output  NUM_PORTS  grant[i]=1: input i's flit is consumed at this rising edge (combinational).
out_data  output  NUM_PORTS*DATA_W  registered output flits; slice o.
out_valid  output  NUM_PORTS  registered; 1 for exactly the cycles in which out_data slice o holds a new flit.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_data=0, out_valid=0, all round-robin pointers ptr[o]=0, all locks cleared.
  - grant is forced to 0 while rst=0.
- Candidates: input i is a candidate for output o when request slice i == o. Each input targets at most one output, so grant has at most one bit set per input.
- Arbitration per output o, LOCK_MODE=0, each cycle:
  - If full[o]=1 or there are no candidates: no grant for o. At the edge, out_valid[o]<=0, out_data slice o holds, ptr[o] is unchanged.
  - Otherwise the winner is the first candidate at index >= ptr[o], wrapping modulo NUM_PORTS. grant[winner]=1.
  - At the edge: out_data slice o <= in_data slice winner, out_valid[o]<=1, ptr[o] <= (winner+1) mod NUM_PORTS.
- Latency: one cycle from grant to out_valid. Sustained throughput is 1 flit/cycle/output. All outputs arbitrate independently and in parallel, so disjoint input/output pairs are granted in the same cycle.
- LOCK_MODE=1:
  - Each output holds lock_v[o] and owner[o].
  - When unlocked and a grant occurs: lock_v<=1 and owner<=winner.
  - While locked, only owner[o] can be granted on o. full[o]=1 suppresses the grant but keeps the lock.
  - Release happens in the first cycle where owner's request != o. In that same cycle o arbitrates normally among the other candidates, starting from ptr=(owner+1) mod NUM_PORTS. If nobody wins, lock_v<=0.
  - ptr[o] is updated only when the lock is taken: ptr <= winner+1.
- A request to the input's own index is legal (loopback); the bench exercises it on port 0.
- Request values in NUM_PORTS..2^REQ_W-1 are all idle and are never granted.
- Changing request or in_data mid-cycle: grant follows combinationally. Only the values present at the rising edge matter.
- Reset asserted mid-transfer: the in-flight flit is dropped, and locks and pointers return to their reset values.

Test Plan:
1. Reset and idle: rst=0 pulse, then all request=7, in_data L..W=1,2,3,5,4 -> grant=0 and out_valid=0 on every cycle, out_data=0.
2. Single flow: request W(4)=0 with in_data W=4 -> grant[4]=1 every cycle; out_data L=4 and out_valid[0]=1 from the next edge.
3. Backpressure: during flow 2, full[0]=1 for 1 cycle while in_data W goes 5 then 6 -> grant[4]=0 and out_valid[0]=0 for that cycle, out_data L holds its last value. After release, in_data W=7 -> out_data L=7 one cycle after grant.
4. Round-robin contention: inputs 1, 2, 3 all request 0, in_data=2,3,5, starting from ptr=0 -> grant sequence 1,2,3,1,... and out_data L sequence 2,3,5,2.
5. Parallel paths: W(4)->L(0) and S(3)->E(2) requested in the same cycle -> grant[4]=grant[3]=1 in that cycle; out_valid[0]=out_valid[2]=1 at the next edge.
6. Lock mode (LOCK_MODE=1): N and E both request L and N wins -> only N is granted for 4 cycles while E waits. N then goes idle -> E is granted in that same cycle and ptr[0]=3 at the next edge.

Source files
------------

// File: rtl/noc_switch_rr.sv
// noc_switch_rr: parametrised crossbar with per-output round-robin arbitration, optional wormhole lock, registered outputs
module noc_switch_rr #(
   parameter int NUM_PORTS = 5,
   parameter int DATA_W    = 8,
   parameter int REQ_W     = 3,
   parameter int LOCK_MODE = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS*REQ_W-1:0]    request,
   input  logic [NUM_PORTS-1:0]          full,
   output logic [NUM_PORTS-1:0]          grant,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic [NUM_PORTS-1:0]          out_valid
);
   logic [REQ_W-1:0]     ptr     [NUM_PORTS];
   logic [REQ_W-1:0]     owner   [NUM_PORTS];
   logic [REQ_W-1:0]     win_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0] lock_v;
   logic [NUM_PORTS-1:0] win_v;
   logic [NUM_PORTS-1:0] held;

   function automatic logic [REQ_W-1:0] inc(input logic [REQ_W-1:0] x);
      return (int'(x) == NUM_PORTS - 1) ? '0 : x + 1'b1;
   endfunction

   // held: output is locked and its owner still wants it, so only the owner may win
   always_comb begin
      int start;
      int idx;
      grant = '0;
      win_v = '0;
      held  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         win_idx[o] = '0;
         held[o] = lock_v[o] && request[int'(owner[o])*REQ_W +: REQ_W] == REQ_W'(o);
         start = lock_v[o] ? int'(owner[o]) + 1 : int'(ptr[o]);
         if (start >= NUM_PORTS) start = 0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = start + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (rst && !full[o] && !win_v[o] && request[idx*REQ_W +: REQ_W] == REQ_W'(o) &&
                (!held[o] || idx == int'(owner[o]))) begin
               win_v[o]   = 1'b1;
               win_idx[o] = REQ_W'(idx);
               grant[idx] = 1'b1;
            end
         end
      end
   end

   // a fresh win (never a held one) moves the pointer and, in lock mode, takes the lock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_valid <= '0;
         lock_v    <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            ptr[o]   <= '0;
            owner[o] <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            out_valid[o] <= win_v[o];
            if (win_v[o]) out_data[o*DATA_W +: DATA_W] <= in_data[int'(win_idx[o])*DATA_W +: DATA_W];
            lock_v[o] <= (LOCK_MODE != 0) && (win_v[o] || held[o]);
            if (win_v[o] && !held[o]) begin
               ptr[o]   <= inc(win_idx[o]);
               owner[o] <= win_idx[o];
            end
         end
      end
   end
endmodule

// File: tb/tb_noc_switch_rr.sv
// tb_noc_switch_rr: scoreboard bench driving a free-running and a lock-mode switch from one stimulus stream
module tb_noc_switch_rr;
   localparam int N = 5, RW = 3, DW = 8;
   localparam logic [N*RW-1:0] IDLE = '1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] in_data, od0, od1;
   logic [N*RW-1:0] request;
   logic [N-1:0]    full, g0, g1, ov0, ov1;

   int ptr [2][N];
   int own [2][N];
   bit lv  [2][N];
   int q   [2][N][$];
   int last [2][N];
   int cyc, total, passed;

   noc_switch_rr #(.NUM_PORTS(N), .DATA_W(DW), .REQ_W(RW), .LOCK_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .request(request), .full(full),
      .grant(g0), .out_data(od0), .out_valid(ov0));
   noc_switch_rr #(.NUM_PORTS(N), .DATA_W(DW), .REQ_W(RW), .LOCK_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .request(request), .full(full),
      .grant(g1), .out_data(od1), .out_valid(ov1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int rq(input int i);
      return int'(request[i*RW +: RW]);
   endfunction

   function automatic int din(input int i);
      return int'(in_data[i*DW +: DW]);
   endfunction

   // reference: per output, winner is the candidate closest after the start point; locks follow packet ownership
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         logic [N-1:0] eg = '0;
         for (int o = 0; o < N; o++) begin
            int w = -1;
            int best = N;
            int start = lv[m][o] ? (own[m][o] + 1) % N : ptr[m][o];
            bit hold = m == 1 && lv[m][o] && rq(own[m][o]) == o;
            if (hold) w = own[m][o];
            else
               for (int i = 0; i < N; i++)
                  if (rq(i) == o && (i - start + N) % N < best) begin
                     best = (i - start + N) % N;
                     w = i;
                  end
            if (full[o]) w = -1;
            if (w >= 0) begin
               eg[w] = 1'b1;
               q[m][o].push_back((cyc + 1) * 256 + din(w));
            end
            if (!hold) begin
               if (w >= 0) begin
                  ptr[m][o] = (w + 1) % N;
                  own[m][o] = w;
                  lv[m][o]  = (m == 1);
               end else lv[m][o] = 1'b0;
            end
         end
         check($sformatf("grant m%0d", m), m ? g1 : g0, eg);
      end
   endtask

   task automatic cycle(input logic [N*RW-1:0] r, input logic [N*DW-1:0] d, input logic [N-1:0] f, input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         request = r;
         in_data = d;
         full    = f;
         #1;
         model_step();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset grant m0", g0, 0);
      check("reset grant m1", g1, 0);
      check("reset valid m0", ov0, 0);
      check("reset valid m1", ov1, 0);
      check("reset data m0", od0, 0);
      check("reset data m1", od1, 0);
      for (int m = 0; m < 2; m++)
         for (int o = 0; o < N; o++) begin
            ptr[m][o] = 0;
            own[m][o] = 0;
            lv[m][o] = 1'b0;
            last[m][o] = 0;
         end
      @(negedge clk);
      #1;
      request = IDLE;
      full    = '0;
      rst     = 1'b1;
   endtask

   initial begin : mon
      logic v;
      int d, e;
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++)
            for (int o = 0; o < N; o++) begin
               v = m ? ov1[o] : ov0[o];
               d = int'(m ? od1[o*DW +: DW] : od0[o*DW +: DW]);
               if (!v) check($sformatf("hold m%0d o%0d", m, o), d, last[m][o]);
               else if (q[m][o].size() == 0) check($sformatf("unexpected valid m%0d o%0d", m, o), v, 1'b0);
               else begin
                  e = q[m][o].pop_front();
                  check($sformatf("data m%0d o%0d", m, o), d, e % 256);
                  check($sformatf("latency m%0d o%0d", m, o), cyc, e / 256);
                  last[m][o] = e % 256;
               end
            end
      end
   end

   initial begin
      logic [N*RW-1:0] r;
      logic [N*DW-1:0] d;
      logic [N-1:0]    f;
      rst = 1'b0;
      request = IDLE;
      in_data = '0;
      full = '0;
      do_reset();
      cycle(IDLE, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 3);
      cycle({3'd0, 12'hfff}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 3);
      cycle({3'd0, 12'hfff}, {8'd5, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 1);
      cycle({3'd0, 12'hfff}, {8'd6, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b00001, 1);
      cycle({3'd0, 12'hfff}, {8'd7, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 2);
      cycle({3'd7, 3'd0, 3'd0, 3'd0, 3'd7}, {8'd0, 8'd5, 8'd3, 8'd2, 8'd0}, 5'b0, 6);
      cycle({3'd0, 3'd2, 3'd7, 3'd7, 3'd7}, {8'd9, 8'd8, 8'd3, 8'd2, 8'd1}, 5'b0, 2);
      do_reset();
      cycle({3'd7, 3'd7, 3'd0, 3'd0, 3'd7}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 4);
      cycle({3'd7, 3'd7, 3'd0, 3'd7, 3'd7}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 2);
      cycle({3'd7, 3'd7, 3'd7, 3'd7, 3'd0}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd11}, 5'b0, 2);
      cycle({3'd5, 3'd6, 3'd5, 3'd6, 3'd7}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 2);
      cycle({3'd0, 3'd2, 3'd2, 3'd0, 3'd0}, {8'd4, 8'd5, 8'd3, 8'd2, 8'd1}, 5'b0, 2);
      do_reset();
      r = IDLE;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) r[i*RW +: RW] = RW'($urandom_range(0, 7));
            d[i*DW +: DW] = DW'($urandom);
            f[i] = ($urandom_range(0, 3) == 0);
         end
         if (c == 300) do_reset();
         cycle(r, d, f, 1);
      end
      cycle(IDLE, '0, 5'b0, 3);
      for (int m = 0; m < 2; m++)
         for (int o = 0; o < N; o++)
            check($sformatf("leftover m%0d o%0d", m, o), q[m][o].size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
